// File: rtl/downsample_engine.sv
// Counter-driven block-averaging downsampler: reads FACTOR x FACTOR source blocks over a
// stall-tolerant memory port, writes one averaged pixel per block back to memory.
module downsample_engine #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int FACTOR = 2,
   parameter int ROUND  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              finish
);

   localparam int L     = $clog2(FACTOR);
   localparam int ACC_W = DATA_W + 2 * L + 1;
   localparam int OW    = IMG_W / FACTOR;
   localparam int OH    = IMG_H / FACTOR;

   localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] F_A   = ADDR_W'(FACTOR);
   localparam logic [ADDR_W-1:0] F_M1  = ADDR_W'(FACTOR - 1);
   localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] OW_A  = ADDR_W'(OW);
   localparam logic [ADDR_W-1:0] OW_M1 = ADDR_W'(OW - 1);
   localparam logic [ADDR_W-1:0] OH_M1 = ADDR_W'(OH - 1);
   localparam logic [ACC_W-1:0]  RND   = ACC_W'((ROUND != 0) ? (1 << (2 * L - 1)) : 0);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
   logic [ADDR_W-1:0]   ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, ky_q, ky_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    sum;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, finish_q, finish_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // Address sums wrap silently at ADDR_W bits.
   function automatic logic [ADDR_W-1:0] src_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] ox,
                                                  input logic [ADDR_W-1:0] oy,
                                                  input logic [ADDR_W-1:0] kx,
                                                  input logic [ADDR_W-1:0] ky);
      return base + (oy * F_A + ky) * W_A + ox * F_A + kx;
   endfunction

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      kx_d     = kx_q;
      ky_d     = ky_q;
      acc_d    = acc_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      finish_d = finish_q;
      sum      = acc_q + ACC_W'(mem_rdata) + RND;

      case (state_q)
         IDLE: begin
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            busy_d = 1'b0;
            addr_d = '0;
            if (start) begin
               src_d    = src_base;
               dst_d    = dst_base;
               ox_d     = '0;
               oy_d     = '0;
               kx_d     = '0;
               ky_d     = '0;
               acc_d    = '0;
               finish_d = 1'b0;
               busy_d   = 1'b1;
               rd_d     = 1'b1;
               addr_d   = src_base;
               state_d  = RD;
            end
         end
         RD: begin
            if (mem_ready) begin
               acc_d = acc_q + ACC_W'(mem_rdata);
               if (kx_q == F_M1 && ky_q == F_M1) begin
                  // Last tap folds the current read straight into the average.
                  wdata_d = DATA_W'(sum >> (2 * L));
                  rd_d    = 1'b0;
                  wr_d    = 1'b1;
                  addr_d  = dst_q + oy_q * OW_A + ox_q;
                  state_d = WR;
               end else begin
                  if (kx_q == F_M1) begin
                     kx_d = '0;
                     ky_d = ky_q + ONE;
                  end else begin
                     kx_d = kx_q + ONE;
                  end
                  addr_d = src_addr(src_q, ox_q, oy_q, kx_d, ky_d);
               end
            end
         end
         WR: begin
            if (mem_ready) begin
               acc_d = '0;
               kx_d  = '0;
               ky_d  = '0;
               wr_d  = 1'b0;
               if (ox_q == OW_M1 && oy_q == OH_M1) begin
                  busy_d   = 1'b0;
                  finish_d = 1'b1;
                  addr_d   = '0;
                  state_d  = IDLE;
               end else begin
                  if (ox_q == OW_M1) begin
                     ox_d = '0;
                     oy_d = oy_q + ONE;
                  end else begin
                     ox_d = ox_q + ONE;
                  end
                  rd_d    = 1'b1;
                  addr_d  = src_addr(src_q, ox_d, oy_d, '0, '0);
                  state_d = RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         kx_q     <= '0;
         ky_q     <= '0;
         acc_q    <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         kx_q     <= kx_d;
         ky_q     <= ky_d;
         acc_q    <= acc_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_rd    = rd_q;
   assign mem_wr    = wr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;
   assign finish    = finish_q;

endmodule

// File: tb/tb_downsample_engine.sv
// Directed bench for downsample_engine: three instances (floor 4x4, round 4x4, FACTOR=4 8x8)
// share a byte memory for reads; writes land in a separate capture array.
module tb_downsample_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  start, ready, rd, wr, busy, fin;
   logic [15:0] src_base [3];
   logic [15:0] dst_base [3];
   logic [15:0] addr [3];
   logic [7:0]  wdata [3];
   logic [7:0]  rdata [3];
   logic [7:0]  mem  [65536];
   logic [7:0]  wmem [65536];
   int          wr_cnt [3] = '{0, 0, 0};
   int          errors = 0;
   int          checks = 0;

   assign rdata[0] = mem[addr[0]];
   assign rdata[1] = mem[addr[1]];
   assign rdata[2] = mem[addr[2]];

   // Memory model: a write completes on the edge where strobe and ready are both high.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (wr[i] && ready[i]) begin
            wmem[addr[i]] <= wdata[i];
            wr_cnt[i]     <= wr_cnt[i] + 1;
         end
      end
   end

   downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(4), .IMG_H(4), .FACTOR(2), .ROUND(0)) dut_floor (
      .clk(clk), .rst(rst), .start(start[0]), .src_base(src_base[0]), .dst_base(dst_base[0]),
      .mem_addr(addr[0]), .mem_rd(rd[0]), .mem_wr(wr[0]), .mem_wdata(wdata[0]),
      .mem_rdata(rdata[0]), .mem_ready(ready[0]), .busy(busy[0]), .finish(fin[0]));

   downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(4), .IMG_H(4), .FACTOR(2), .ROUND(1)) dut_round (
      .clk(clk), .rst(rst), .start(start[1]), .src_base(src_base[1]), .dst_base(dst_base[1]),
      .mem_addr(addr[1]), .mem_rd(rd[1]), .mem_wr(wr[1]), .mem_wdata(wdata[1]),
      .mem_rdata(rdata[1]), .mem_ready(ready[1]), .busy(busy[1]), .finish(fin[1]));

   downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(8), .IMG_H(8), .FACTOR(4), .ROUND(0)) dut_big (
      .clk(clk), .rst(rst), .start(start[2]), .src_base(src_base[2]), .dst_base(dst_base[2]),
      .mem_addr(addr[2]), .mem_rd(rd[2]), .mem_wr(wr[2]), .mem_wdata(wdata[2]),
      .mem_rdata(rdata[2]), .mem_ready(ready[2]), .busy(busy[2]), .finish(fin[2]));

   // Start is sampled on the posedge between the two negedges; returns at the following negedge.
   task automatic pulse_start(input int idx, input logic [15:0] src, input logic [15:0] dst);
      @(negedge clk);
      src_base[idx] = src;
      dst_base[idx] = dst;
      start[idx]    = 1'b1;
      @(negedge clk);
      start[idx]    = 1'b0;
   endtask

   // Counts edges after the start edge until finish is seen, bounded by a cycle budget.
   task automatic wait_finish(input int idx, inout int cycles);
      while (fin[idx] !== 1'b1 && cycles < 400) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = '0;
      ready = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rd[i], wr[i], busy[i], fin[i]} !== 4'b0000 || addr[i] !== 16'h0000 || wdata[i] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_state[%0d]: rd=%b wr=%b busy=%b fin=%b addr=%h wdata=%h, expected all zero",
                     i, rd[i], wr[i], busy[i], fin[i], addr[i], wdata[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_floor;
      logic [7:0] exp_px [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
      int cycles = 0;
      int wr0 = wr_cnt[0];
      pulse_start(0, 16'h0100, 16'h0200);
      checks++;
      if (busy[0] !== 1'b1 || rd[0] !== 1'b1 || addr[0] !== 16'h0100) begin
         errors++;
         $display("[TB] FAIL floor_first_read: busy=%b rd=%b addr=%h, expected 1 1 0100", busy[0], rd[0], addr[0]);
      end
      wait_finish(0, cycles);
      checks++;
      if (cycles !== 20) begin
         errors++;
         $display("[TB] FAIL floor_cycles: got %0d expected 20", cycles);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wmem[16'h0200 + 16'(i)] !== exp_px[i]) begin
            errors++;
            $display("[TB] FAIL floor_data[%0d]: got %0d expected %0d", i, wmem[16'h0200 + 16'(i)], exp_px[i]);
         end
      end
      checks++;
      if (wr_cnt[0] - wr0 !== 4) begin
         errors++;
         $display("[TB] FAIL floor_write_count: got %0d expected 4", wr_cnt[0] - wr0);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (fin[0] !== 1'b1 || busy[0] !== 1'b0 || rd[0] !== 1'b0 || wr[0] !== 1'b0 || addr[0] !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL finish_sticky: fin=%b busy=%b rd=%b wr=%b addr=%h, expected 1 0 0 0 0000",
                  fin[0], busy[0], rd[0], wr[0], addr[0]);
      end
   endtask

   task automatic test_round;
      logic [7:0] exp_px [4] = '{8'd3, 8'd5, 8'd11, 8'd13};
      int cycles = 0;
      pulse_start(1, 16'h0100, 16'h0220);
      wait_finish(1, cycles);
      checks++;
      if (cycles !== 20) begin
         errors++;
         $display("[TB] FAIL round_cycles: got %0d expected 20", cycles);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wmem[16'h0220 + 16'(i)] !== exp_px[i]) begin
            errors++;
            $display("[TB] FAIL round_data[%0d]: got %0d expected %0d", i, wmem[16'h0220 + 16'(i)], exp_px[i]);
         end
      end
   endtask

   task automatic test_saturate;
      int cycles = 0;
      int wr0 = wr_cnt[2];
      pulse_start(2, 16'h1000, 16'h2000);
      wait_finish(2, cycles);
      checks++;
      if (cycles !== 68) begin
         errors++;
         $display("[TB] FAIL big_cycles: got %0d expected 68", cycles);
      end
      checks++;
      if (wr_cnt[2] - wr0 !== 4) begin
         errors++;
         $display("[TB] FAIL big_write_count: got %0d expected 4", wr_cnt[2] - wr0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wmem[16'h2000 + 16'(i)] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL big_data[%0d]: got %h expected ff", i, wmem[16'h2000 + 16'(i)]);
         end
      end
   endtask

   task automatic test_stall;
      logic [7:0]  exp_px [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
      logic [15:0] s_addr;
      logic [7:0]  s_wdata;
      logic        s_rd, s_wr, stalled;
      int cycles = 0;
      int stalls = 0;
      int unstable = 0;
      stalled = 1'b0;
      s_addr = '0; s_wdata = '0; s_rd = 1'b0; s_wr = 1'b0;
      pulse_start(0, 16'h0100, 16'h0600);
      while (cycles < 400) begin
         if (stalled && (addr[0] !== s_addr || rd[0] !== s_rd || wr[0] !== s_wr || wdata[0] !== s_wdata))
            unstable++;
         if (fin[0] === 1'b1) break;
         ready[0] = 1'($urandom_range(0, 1));
         s_addr   = addr[0];
         s_rd     = rd[0];
         s_wr     = wr[0];
         s_wdata  = wdata[0];
         stalled  = !ready[0] && (rd[0] || wr[0]);
         if (stalled) stalls++;
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      ready[0] = 1'b1;
      checks++;
      if (cycles !== 20 + stalls) begin
         errors++;
         $display("[TB] FAIL stall_cycles: got %0d expected %0d", cycles, 20 + stalls);
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("[TB] FAIL stall_stable: got %0d changed stall cycles expected 0", unstable);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wmem[16'h0600 + 16'(i)] !== exp_px[i]) begin
            errors++;
            $display("[TB] FAIL stall_data[%0d]: got %0d expected %0d", i, wmem[16'h0600 + 16'(i)], exp_px[i]);
         end
      end
   endtask

   task automatic test_reset_midjob;
      logic [7:0] exp_px [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
      int cycles = 0;
      int wr0 = wr_cnt[0];
      int wr1;
      pulse_start(0, 16'h0100, 16'h0280);
      repeat (2) @(negedge clk);
      checks++;
      if (rd[0] !== 1'b1 || addr[0] !== 16'h0104) begin
         errors++;
         $display("[TB] FAIL third_read: rd=%b addr=%h expected 1 0104", rd[0], addr[0]);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({rd[0], wr[0], busy[0], fin[0]} !== 4'b0000 || addr[0] !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL midjob_reset: rd=%b wr=%b busy=%b fin=%b addr=%h expected all zero",
                  rd[0], wr[0], busy[0], fin[0], addr[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rd[0] !== 1'b0 || wr_cnt[0] !== wr0) begin
         errors++;
         $display("[TB] FAIL abandoned_job: rd=%b writes=%0d expected 0 and %0d", rd[0], wr_cnt[0], wr0);
      end
      wr1 = wr_cnt[0];
      pulse_start(0, 16'h0100, 16'h0300);
      repeat (2) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      @(negedge clk);
      src_base[0] = 16'h0500;
      dst_base[0] = 16'h0400;
      start[0]    = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
      start[0]    = 1'b0;
      wait_finish(0, cycles);
      checks++;
      if (cycles !== 20) begin
         errors++;
         $display("[TB] FAIL restart_cycles: got %0d expected 20", cycles);
      end
      checks++;
      if (wr_cnt[0] - wr1 !== 4) begin
         errors++;
         $display("[TB] FAIL restart_write_count: got %0d expected 4", wr_cnt[0] - wr1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wmem[16'h0300 + 16'(i)] !== exp_px[i]) begin
            errors++;
            $display("[TB] FAIL restart_data[%0d]: got %0d expected %0d", i, wmem[16'h0300 + 16'(i)], exp_px[i]);
         end
      end
   endtask

   task automatic test_wrap;
      logic [15:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0002, 16'h0003};
      logic [15:0] exp_d [4] = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
      logic [7:0]  exp_px [4] = '{8'd10, 8'd18, 8'd42, 8'd50};
      logic [15:0] got [4];
      int cycles = 0;
      pulse_start(0, 16'hFFFE, 16'hFFFD);
      got[0] = addr[0];
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         got[k] = addr[0];
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got[k] !== exp_a[k]) begin
            errors++;
            $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", k, got[k], exp_a[k]);
         end
      end
      wait_finish(0, cycles);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wmem[exp_d[i]] !== exp_px[i]) begin
            errors++;
            $display("[TB] FAIL wrap_data[%0d]: got %0d expected %0d at %h", i, wmem[exp_d[i]], exp_px[i], exp_d[i]);
         end
      end
   endtask

   initial begin
      logic [15:0] a;
      rst   = 1'b1;
      start = '0;
      ready = 3'b111;
      for (int i = 0; i < 3; i++) begin
         src_base[i] = '0;
         dst_base[i] = '0;
      end
      for (int p = 0; p < 16; p++) mem[16'h0100 + 16'(p)] = 8'(p);
      for (int p = 0; p < 64; p++) mem[16'h1000 + 16'(p)] = 8'hFF;
      for (int p = 0; p < 16; p++) begin
         a = 16'hFFFE + 16'(p);
         mem[a] = 8'(4 * p);
      end

      test_reset;
      test_floor;
      test_round;
      test_saturate;
      test_stall;
      test_reset_midjob;
      test_wrap;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/downsample_engine.md
# downsample_engine

Hardwired, parametrised successor to the microcoded downsampling processor: reads a source image from data memory, averages each FACTOR×FACTOR pixel block, and writes the reduced image back to memory. It replaces the microcode, register-file and ALU loop with a counter-driven FSM. It has a stall-tolerant memory handshake and a selectable rounding mode. It sits on the same data-memory port the processor used: one address bus, separate read and write strobes, and a byte-lane data path.

## Interface
- DATA_W, 8: pixel width in bits.
- ADDR_W, 16: memory address width.
- IMG_W, 256: source width in pixels; must be a multiple of FACTOR.
- IMG_H, 256: source height in pixels; must be a multiple of FACTOR.
- FACTOR, 2: downsampling factor; must be a power of two in the range 2..16. L = log2(FACTOR).
- ROUND, 0: 0 selects floor (truncate); 1 selects round-half-up.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- src_base  in  ADDR_W  source image base address; latched on an accepted start.
- dst_base  in  ADDR_W  destination base address; latched on an accepted start.
- mem_addr  out  ADDR_W  memory address; reset value 0.
- mem_rd  out  1  read request; reset value 0.
- mem_wr  out  1  write request; reset value 0.
- mem_wdata  out  DATA_W  write data; reset value 0.
- mem_rdata  in  DATA_W  read data; valid in the cycle where mem_rd=1 and mem_ready=1.
- mem_ready  in  1  memory accepts or completes the current request this cycle.
- busy  out  1  job in progress; reset value 0.
- finish  out  1  sticky completion flag; reset value 0.

## Operation
- Output dimensions: OW = IMG_W/FACTOR, OH = IMG_H/FACTOR.
- FSM states:
  - IDLE: mem_rd, mem_wr and busy are 0; mem_addr is held at 0.
    - On start=1: latch both bases, clear counters ox, oy, kx, ky and the accumulator, clear finish, set busy, go to RD.
  - RD: mem_rd=1 with mem_addr = src_base + (oy·FACTOR+ky)·IMG_W + ox·FACTOR + kx.
    - On mem_ready: acc += mem_rdata, then advance kx (inner loop) and ky (outer loop).
    - On the last tap (kx = ky = FACTOR−1): go to WR with mem_wdata = (acc + mem_rdata + R) >> 2L, where R = 2^(2L−1) if ROUND=1, otherwise 0.
  - WR: mem_wr=1 with mem_addr = dst_base + oy·OW + ox; mem_wdata is held stable.
    - On mem_ready: clear acc, advance ox (inner loop) and oy (outer loop), then go to RD.
    - On the final output (ox = OW−1, oy = OH−1): go to IDLE instead, with busy=0 and finish=1.
- Arithmetic and width rules:
  - The accumulator is DATA_W + 2L + 1 bits wide, so it never overflows.
  - The result never exceeds 2^DATA_W − 1; no saturation logic is needed.
  - Address sums are computed modulo 2^ADDR_W and wrap silently.
- Boundary conditions:
  - start while busy: ignored, with no effect on counters or bases.
  - finish stays 1 until the next accepted start or rst.
  - rst in any state: the next edge forces IDLE and all outputs to their reset values. An in-flight request is abandoned and no further strobes are issued.
  - mem_ready=0: the FSM holds state; mem_addr, mem_rd, mem_wr and mem_wdata stay unchanged.
  - mem_ready is ignored in IDLE.

## Timing
- Memory requests are registered outputs. A request is completed on the edge where mem_ready=1.
- Read data is consumed on that same edge; there is no extra latency cycle.
- Start sampled at edge N: mem_rd=1 from edge N+1.
- With mem_ready tied to 1:
  - Each output pixel costs exactly FACTOR² + 1 cycles.
  - The last write completes at edge N + OW·OH·(FACTOR²+1), which leaves busy=0 and finish=1.
- Each cycle with mem_ready=0 while mem_rd or mem_wr is asserted adds exactly one cycle to the job.
- mem_rd and mem_wr are never asserted together.
- Back-to-back jobs: start may be accepted on the first cycle after finish rises.

## Test plan
- Floor mode, IMG 4×4, FACTOR=2, source pixel values 0..15 at base 0x0100, dst_base=0x0200, mem_ready=1.
  - Required: writes 2, 4, 10, 12 to 0x0200..0x0203.
  - Required: finish rises exactly 20 cycles after start.
- Same image with ROUND=1.
  - Required: writes 3, 5, 11, 13.
- All source pixels 0xFF, FACTOR=4, IMG 8×8.
  - Required: four writes, each 0xFF (no overflow).
  - Required: total of 68 cycles.
- Random mem_ready with 50% duty.
  - Required: the same output data as the ready=1 run.
  - Required: address and strobes stable while ready=0.
  - Required: cycle count equals the ideal count plus the number of stalled cycles.
- rst asserted during the third read of a job, followed by a new start.
  - Required: the next edge gives rd=wr=busy=finish=0 and mem_addr=0.
  - Required: the new job produces correct output.
  - Required: a start pulse during busy is ignored.
- src_base=0xFFFE on a 4×4 image.
  - Required: the first read addresses are 0xFFFE, 0xFFFF, 0x0002, 0x0003.
  - Required: all addresses wrap modulo 2^16.
